// File: rtl/seg_display_pkg.sv
// Definitions shared by the 7-segment scan driver and the scan monitor:
// active-low segment patterns, the blank anode word and the monitor FSM states.
package seg_display_pkg;

    typedef enum logic [1:0] {
        SCAN_IDLE    = 2'd0,
        SCAN_SETTLE  = 2'd1,
        SCAN_CAPTURE = 2'd2,
        SCAN_HOLD    = 2'd3
    } scan_state_e;

    // Active-low cathode patterns, bit0 = segment a ... bit6 = segment g.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int              MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] ANODE_IDLE = '1;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational reverse lookup of an active-low 7-segment pattern to a hex nibble.
// hit_o is low for any pattern outside the 16-entry table, including blank.
module seg_pattern_decode
    import seg_display_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       hit_o
);

    always_comb begin
        nibble_o = 4'h0;
        hit_o    = 1'b1;
        case (pattern_i)
            SEG_0:   nibble_o = 4'h0;
            SEG_1:   nibble_o = 4'h1;
            SEG_2:   nibble_o = 4'h2;
            SEG_3:   nibble_o = 4'h3;
            SEG_4:   nibble_o = 4'h4;
            SEG_5:   nibble_o = 4'h5;
            SEG_6:   nibble_o = 4'h6;
            SEG_7:   nibble_o = 4'h7;
            SEG_8:   nibble_o = 4'h8;
            SEG_9:   nibble_o = 4'h9;
            SEG_A:   nibble_o = 4'hA;
            SEG_B:   nibble_o = 4'hB;
            SEG_C:   nibble_o = 4'hC;
            SEG_D:   nibble_o = 4'hD;
            SEG_E:   nibble_o = 4'hE;
            SEG_F:   nibble_o = 4'hF;
            default: hit_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_monitor.sv
// Receive-side monitor for a multiplexed 7-segment display: settles, captures and decodes
// each scanned digit. Define SEG_SCAN_MONITOR_DP_EN to also capture decimal points.
module seg_scan_monitor
    import seg_display_pkg::*;
#(
    parameter int         NUM_DIGITS    = 8,
    parameter int         SETTLE_CYCLES = 16,
    parameter logic [7:0] DIGIT_MASK    = 8'h03
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_DIGITS-1:0]   anode,
    input  logic [6:0]              cathode,
    input  logic                    dp,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   illegal_seg,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic                    frame_done,
    output logic                    scan_error
);

    localparam logic [1:0] ST_IDLE    = SCAN_IDLE;
    localparam logic [1:0] ST_SETTLE  = SCAN_SETTLE;
    localparam logic [1:0] ST_CAPTURE = SCAN_CAPTURE;
    localparam logic [1:0] ST_HOLD    = SCAN_HOLD;

    localparam logic [15:0]           CNT_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] MASK     = DIGIT_MASK[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] BLANK    = ANODE_IDLE[NUM_DIGITS-1:0];

`ifdef SEG_SCAN_MONITOR_DP_EN
    localparam int WORD_W = NUM_DIGITS + 8;
`else
    localparam int WORD_W = NUM_DIGITS + 7;
`endif

    logic [WORD_W-1:0]       word_in;
    logic [WORD_W-1:0]       sync1_q;
    logic [WORD_W-1:0]       sync2_q;
    logic [NUM_DIGITS-1:0]   s_anode;
    logic [6:0]              s_cathode;
    logic                    s_dp;
    logic [NUM_DIGITS-1:0]   low;
    logic                    stable, blank, one_low, multi_low;
    logic [1:0]              state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [3:0]              dec_nibble;
    logic                    dec_hit;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   illegal_q, illegal_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   set_q, set_d;
    logic                    frame_q, frame_d;
    logic                    scan_err_q, scan_err_d;

`ifdef SEG_SCAN_MONITOR_DP_EN
    assign word_in = {dp, cathode, anode};
    assign s_dp    = sync2_q[NUM_DIGITS+7];
`else
    logic unused_dp;
    assign unused_dp = dp;
    assign word_in   = {cathode, anode};
    assign s_dp      = 1'b1;
`endif

    assign s_anode   = sync2_q[NUM_DIGITS-1:0];
    assign s_cathode = sync2_q[NUM_DIGITS+6:NUM_DIGITS];
    // The newest synchronized sample is compared with the one before it.
    assign stable    = (sync1_q == sync2_q);
    assign blank     = (s_anode == BLANK);
    assign low       = ~s_anode;
    assign one_low   = (low != '0) && ((low & (low - 1'b1)) == '0);
    assign multi_low = (low != '0) && !one_low;

    seg_pattern_decode u_decode (
        .pattern_i (s_cathode),
        .nibble_o  (dec_nibble),
        .hit_o     (dec_hit)
    );

    always_comb begin
        if (!stable)
            cnt_d = '0;
        else if (cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
        else
            cnt_d = cnt_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (!blank) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (blank)
                    state_d = ST_IDLE;
                else if (stable && cnt_q == CNT_LAST)
                    state_d = ST_CAPTURE;
            end
            ST_CAPTURE: state_d = stable ? ST_HOLD : ST_SETTLE;
            default:    if (!stable) state_d = blank ? ST_IDLE : ST_SETTLE;
        endcase
    end

    always_comb begin
        digits_d   = digits_q;
        valid_d    = valid_q;
        illegal_d  = illegal_q;
        dp_d       = dp_q;
        set_d      = set_q;
        frame_d    = 1'b0;
        scan_err_d = 1'b0;
        if (state_q == ST_CAPTURE) begin
            if (one_low) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (low[i]) begin
                        if (dec_hit)
                            digits_d[4*i +: 4] = dec_nibble;
                        valid_d[i]   = dec_hit;
                        illegal_d[i] = !dec_hit;
`ifdef SEG_SCAN_MONITOR_DP_EN
                        dp_d[i]      = !s_dp;
`endif
                    end
                end
                set_d = set_q | low;
                if ((set_d & MASK) == MASK) begin
                    frame_d = 1'b1;
                    set_d   = '0;
                end
            end else if (multi_low) begin
                scan_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            digits_q   <= '0;
            valid_q    <= '0;
            illegal_q  <= '0;
            dp_q       <= '0;
            set_q      <= '0;
            frame_q    <= 1'b0;
            scan_err_q <= 1'b0;
        end else begin
            sync1_q    <= word_in;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            illegal_q  <= illegal_d;
            dp_q       <= dp_d;
            set_q      <= set_d;
            frame_q    <= frame_d;
            scan_err_q <= scan_err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign illegal_seg = illegal_q;
    assign dp_out      = dp_q;
    assign frame_done  = frame_q;
    assign scan_error  = scan_err_q;

endmodule
